// File: rtl/ad9866_spi_ctrl.sv
// ad9866_spi_ctrl
// Write-only SPI master for the AD9866 configuration port. After reset it
// waits STARTUP clocks, then sends the INIT_TABLE register writes (entry 0
// first). After that it serves single host register writes through a
// req/ack handshake.
//
// Ports
//   clk        SPI state-machine clock (IF_clk)
//   rst_n      asynchronous active-low reset
//   wr_req     level request for a host register write
//   wr_addr    register address, latched in the wr_ack cycle's launching edge
//   wr_data    register data, latched together with wr_addr
//   wr_ack     one-cycle pulse: the request was accepted
//   busy       low only while idle with no frame in progress
//   init_done  sticky flag, set once the last init frame has completed
//   sclk       SPI clock (idle low)
//   sdio       SPI data, MSB first, changes on sclk falling edges
//   sen_n      SPI enable, active low
module ad9866_spi_ctrl #(
    parameter int                   CLK_DIV    = 8,
    parameter int                   STARTUP    = 1024,
    parameter int                   INIT_N     = 4,
    parameter logic [INIT_N*14-1:0] INIT_TABLE = {INIT_N{14'h0}}
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic       init_done,
    output logic       sclk,
    output logic       sdio,
    output logic       sen_n
);

    typedef enum logic [2:0] {
        WAIT,
        INIT_LOAD,
        SHIFT,
        GAP,
        IDLE,
        HOST_LOAD
    } state_t;

    localparam logic [15:0] START_LAST = 16'(STARTUP - 1);
    localparam logic [15:0] START_MAX  = 16'(STARTUP);
    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0]  IDX_LAST   = 4'(INIT_N - 1);
    localparam logic [4:0]  BIT_LAST   = 5'd23;

    state_t      state;
    logic [15:0] start_cnt;
    logic [7:0]  half_cnt;
    logic [4:0]  bit_cnt;
    logic        phase;       // 0: sclk low half of a bit, 1: sclk high half
    logic [3:0]  idx;
    logic [22:0] shreg;       // bits still to be sent after the one on sdio
    logic [5:0]  host_addr;
    logic [7:0]  host_data;
    logic [13:0] init_entry;
    logic [23:0] load_frame;
    logic        shift_en;

    // Frame: write bit, 1-byte length, 7 zero address MSBs, addr, data.
    function automatic logic [23:0] make_frame(input logic [5:0] a, input logic [7:0] d);
        return {1'b0, 2'b00, 7'b0, a, d};
    endfunction

    always_comb begin
        init_entry = INIT_TABLE[int'(idx)*14 +: 14];
        load_frame = make_frame(init_entry[13:8], init_entry[7:0]);
        if (state == HOST_LOAD) begin
            load_frame = make_frame(host_addr, host_data);
        end
    end

    // The next bit goes out at the end of a high half, i.e. on sclk falling.
    assign shift_en = (state == SHIFT) && (half_cnt == DIV_LAST) && phase &&
                      (bit_cnt != BIT_LAST);

    // Data path: host payload latch and frame shift register (no reset needed).
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_req) begin
            host_addr <= wr_addr;
            host_data <= wr_data;
        end
        if (state == INIT_LOAD || state == HOST_LOAD) begin
            shreg <= load_frame[22:0];
        end else if (shift_en) begin
            shreg <= {shreg[21:0], 1'b0};
        end
    end

    // Control state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT;
            start_cnt <= '0;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            idx       <= '0;
            wr_ack    <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            sclk      <= 1'b0;
            sdio      <= 1'b0;
            sen_n     <= 1'b1;
        end else begin
            wr_ack <= 1'b0;
            case (state)
                WAIT: begin
                    if (start_cnt != START_MAX) begin
                        start_cnt <= start_cnt + 16'd1;
                    end
                    if (start_cnt == START_LAST) begin
                        state <= INIT_LOAD;
                        idx   <= '0;
                    end
                end
                INIT_LOAD, HOST_LOAD: begin
                    sdio     <= load_frame[23];
                    sen_n    <= 1'b0;
                    sclk     <= 1'b0;
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    phase    <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (half_cnt == DIV_LAST) begin
                        half_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            sclk  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            sclk  <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                sen_n <= 1'b1;
                                sdio  <= 1'b0;
                                state <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                sdio    <= shreg[22];
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (half_cnt == DIV_LAST) begin
                        half_cnt <= '0;
                        if (init_done) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (idx == IDX_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= INIT_LOAD;
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                IDLE: begin
                    if (wr_req) begin
                        wr_ack <= 1'b1;
                        busy   <= 1'b1;
                        state  <= HOST_LOAD;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
// Self-checking bench for ad9866_spi_ctrl. A timeline model predicts, per
// cycle, sen_n/sclk/sdio/busy/init_done/wr_ack from frame start cycles and
// frame words; a monitor also reassembles each frame from sdio at sclk rises.
module tb_ad9866_spi_ctrl;

    localparam int D      = 2;
    localparam int SU     = 10;
    localparam int N      = 2;
    localparam logic [N*14-1:0] TABLE = {14'h0A55, 14'h0F3C};
    localparam int FRAME  = 48 * D;       // sen_n low cycles per frame
    localparam int PERIOD = 49 * D + 1;   // sen_n fall to next fall during init

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ack, busy, init_done, sclk, sdio, sen_n;

    ad9866_spi_ctrl #(
        .CLK_DIV(D), .STARTUP(SU), .INIT_N(N), .INIT_TABLE(TABLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .init_done(init_done),
        .sclk(sclk), .sdio(sdio), .sen_n(sen_n)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural timeline model ----------------
    bit          model_on = 1'b0;
    int          cyc;
    int          start_q[$];
    logic [23:0] word_q[$];
    int          idle_from, init_end, ack_cyc, last_ack_cyc, cur_bit;
    logic        prev_sclk, prev_sen;
    logic [23:0] cap, last_cap;
    logic [23:0] cap_log[$];
    int          rises, low_run, high_run, frames_seen, act_idx, last_low, last_rises;
    int          m_idx, t_in;
    logic        e_sen, e_sclk, e_sdio;

    function automatic logic [23:0] frame_word(input logic [5:0] a, input logic [7:0] d);
        return {1'b0, 2'b00, 7'b0, a, d};
    endfunction

    task automatic model_reset();
        start_q.delete();
        word_q.delete();
        cap_log.delete();
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            logic [13:0] e;
            e = TABLE[i*14 +: 14];
            start_q.push_back(SU + 1 + i * PERIOD);
            word_q.push_back(frame_word(e[13:8], e[7:0]));
        end
        init_end  = start_q[N-1] + FRAME + D;
        idle_from = init_end;
        ack_cyc   = -1;
        last_ack_cyc = -1;
        prev_sclk = 1'b0; prev_sen = 1'b1;
        cap = '0; last_cap = '0; rises = 0; low_run = 0; high_run = 0;
        frames_seen = 0; act_idx = -1; cur_bit = -1; last_low = 0; last_rises = 0;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            cyc++;
            m_idx = -1;
            foreach (start_q[i]) begin
                if (start_q[i] <= cyc && cyc < start_q[i] + FRAME) m_idx = i;
            end
            if (m_idx >= 0) begin
                t_in    = cyc - start_q[m_idx];
                e_sen   = 1'b0;
                e_sclk  = ((t_in / D) % 2) == 1;
                e_sdio  = word_q[m_idx][23 - t_in / (2 * D)];
                cur_bit = t_in / (2 * D);
            end else begin
                e_sen = 1'b1; e_sclk = 1'b0; e_sdio = 1'b0; cur_bit = -1;
            end
            chk("sen_n", {31'b0, sen_n}, {31'b0, e_sen});
            chk("sclk", {31'b0, sclk}, {31'b0, e_sclk});
            chk("sdio", {31'b0, sdio}, {31'b0, e_sdio});
            chk("busy", {31'b0, busy}, {31'b0, cyc < idle_from});
            chk("init_done", {31'b0, init_done}, {31'b0, cyc >= init_end});
            chk("wr_ack", {31'b0, wr_ack}, {31'b0, cyc == ack_cyc});

            // Frame monitor: reassemble words from sdio at sclk rising edges.
            if (!sen_n && prev_sen) begin
                if (frames_seen > 0) begin
                    vectors++;
                    if (high_run < D) begin
                        miscompares++;
                        $display("FAIL gap_high: got %0d cycles, expected at least %0d", high_run, D);
                    end
                end
                low_run = 0; rises = 0; cap = '0; act_idx = m_idx;
            end
            if (sen_n && !prev_sen) begin
                chk("frame_rises", rises, 24);
                chk("frame_low_cycles", low_run, FRAME);
                if (act_idx >= 0) chk("frame_word", cap, word_q[act_idx]);
                last_cap = cap; last_low = low_run; last_rises = rises;
                cap_log.push_back(cap);
                frames_seen++;
                high_run = 0;
            end
            if (sclk && !prev_sclk) begin
                cap = {cap[22:0], sdio};
                rises++;
            end
            if (!sen_n) low_run++; else high_run++;

            // Host request accepted at the first idle cycle it is seen in.
            if (wr_req && cyc >= idle_from && cyc >= init_end) begin
                ack_cyc      = cyc + 1;
                last_ack_cyc = cyc + 1;
                start_q.push_back(cyc + 2);
                word_q.push_back(frame_word(wr_addr, wr_data));
                idle_from = cyc + 2 + FRAME + D;
            end
            prev_sclk = sclk;
            prev_sen  = sen_n;
        end
    end

    // ---------------- stimulus ----------------
    int dut_ack_cyc;

    task automatic host_write(input logic [5:0] a, input logic [7:0] d, input string name);
        int n;
        @(posedge clk); #1;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        n = 0;
        while (wr_ack !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_ack_seen"}, {31'b0, wr_ack}, 32'd1);
        dut_ack_cyc = cyc + 1;
        wr_req = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n;
        n = 0;
        while (frames_seen < target && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, frames_seen, target);
    endtask

    task automatic release_reset();
        @(negedge clk); #1;
        model_reset();
        model_on = 1'b1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sen_n", {31'b0, sen_n}, 32'd1);
        chk("rst_sclk", {31'b0, sclk}, 32'd0);
        chk("rst_sdio", {31'b0, sdio}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_wr_ack", {31'b0, wr_ack}, 32'd0);

        release_reset();
        // Pin the model to hand-computed values.
        chk("model_first_fall", start_q[0], 11);
        chk("model_init_end", init_end, 208);
        chk("model_word0", word_q[0], 24'h000F3C);
        chk("model_word1", word_q[1], 24'h000A55);

        // Request raised during init: held off until the first idle cycle.
        repeat (20) @(posedge clk);
        host_write(6'h01, 8'h11, "init_req");
        chk("init_req_ack_cycle", dut_ack_cyc, 209);
        chk("init_req_word", word_q[word_q.size()-1], 24'h000111);
        wait_frames(3, "frames_after_init_req");
        chk("init_req_captured", last_cap, 24'h000111);

        // Single directed write.
        host_write(6'h09, 8'hA7, "directed");
        chk("directed_word", word_q[word_q.size()-1], 24'h0009A7);
        wait_frames(4, "frames_after_directed");
        chk("directed_captured", last_cap, 24'h0009A7);
        chk("directed_rises", last_rises, 24);
        chk("directed_low", last_low, 96);

        // Request held high with a payload that changes after every ack.
        @(posedge clk); #1;
        wr_addr = 6'($urandom); wr_data = 8'($urandom); wr_req = 1'b1;
        got = 0; n = 0;
        while (got < 4 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (wr_ack === 1'b1) begin
                got++;
                wr_addr = 6'($urandom); wr_data = 8'($urandom);
            end
        end
        wr_req = 1'b0;
        chk("held_req_acks", got, 4);
        wait_frames(8, "frames_after_held");

        // Randomized writes with random idle spacing.
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 30)) @(posedge clk);
            host_write(6'($urandom), 8'($urandom), "random");
        end
        wait_frames(11, "frames_after_random");

        // Reset in the middle of the last random frame, at bit 10.
        n = 0;
        @(negedge clk); #1;
        while (cur_bit != 10 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reached_bit10", cur_bit, 10);
        model_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_sen_n", {31'b0, sen_n}, 32'd1);
        chk("midrst_sclk", {31'b0, sclk}, 32'd0);
        chk("midrst_sdio", {31'b0, sdio}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd1);
        chk("midrst_init_done", {31'b0, init_done}, 32'd0);
        repeat (3) @(negedge clk);
        release_reset();
        wait_frames(N, "replay_frames");
        chk("replay_word0", cap_log[0], 24'h000F3C);
        chk("replay_word1", cap_log[1], 24'h000A55);
        repeat (D + 4) @(negedge clk);
        #1;
        chk("replay_init_done", {31'b0, init_done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
